// File: rtl/cpu_prog_loader.sv
// cpu_prog_loader
//   Loader stage in front of the 19-bit CPU core. Host words arrive over a
//   valid/ready handshake and are written one per cycle into instruction
//   memory. When the image is complete, the core enable is raised for a run
//   window. A word count and an XOR checksum of the image are kept so the
//   host can verify what was loaded.
//
// Handshake: a word is transferred on a rising edge where host_valid and
//   host_ready are both high. host_ready is registered and only high in LOAD.
//   The host may hold host_valid, host_data and host_last for any number of
//   cycles. A beat is consumed only on an edge where host_ready is also high.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   start           begin a load (IDLE only)
//   stop            abort a load (LOAD) or end the run (RUN)
//   clr_err         leave FAULT, clear err_ovf
//   host_valid/host_data/host_last/host_ready   host word stream
//   we_IM/codein/im_addr                        instruction memory write port
//   en              core enable (RUN window)
//   busy            high in LOAD, WRITE_LAST or RUN
//   done            one-cycle pulse after a normal end of run
//   err_ovf         sticky image overflow flag
//   word_count      words written by the current or last load
//   checksum        XOR of words written by the current or last load
//   dbg_state       current FSM state encoding, for observation
module cpu_prog_loader #(
    parameter int unsigned DEPTH      = 4096,
    parameter int unsigned AW         = 12,
    parameter int unsigned RUN_CYCLES = 0
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic          stop,
    input  logic          clr_err,
    input  logic          host_valid,
    input  logic [18:0]   host_data,
    input  logic          host_last,
    output logic          host_ready,
    output logic          we_IM,
    output logic [18:0]   codein,
    output logic [AW-1:0] im_addr,
    output logic          en,
    output logic          busy,
    output logic          done,
    output logic          err_ovf,
    output logic [AW:0]   word_count,
    output logic [18:0]   checksum,
    output logic [2:0]    dbg_state
);

    typedef enum logic [2:0] {
        S_IDLE       = 3'd0,
        S_LOAD       = 3'd1,
        S_WRITE_LAST = 3'd2,
        S_RUN        = 3'd3,
        S_FAULT      = 3'd4
    } state_t;

    localparam logic          RUN_BOUNDED = (RUN_CYCLES != 0);
    localparam logic [31:0]   RUN_LAST    = (RUN_CYCLES != 0) ? 32'(RUN_CYCLES - 1) : 32'd0;
    // word_count doubles as the next write slot; this is the last legal slot.
    localparam logic [AW:0]   LAST_SLOT   = (AW+1)'(DEPTH - 1);

    state_t        state_q, state_d;
    logic          host_ready_q, host_ready_d;
    logic          we_im_q, we_im_d;
    logic [18:0]   codein_q, codein_d;
    logic [AW-1:0] im_addr_q, im_addr_d;
    logic          en_q, en_d;
    logic          busy_q, busy_d;
    logic          done_q, done_d;
    logic          err_ovf_q, err_ovf_d;
    logic [AW:0]   word_count_q, word_count_d;
    logic [18:0]   checksum_q, checksum_d;
    logic [31:0]   run_cnt_q, run_cnt_d;
    logic          accept;

    // host_ready_q is only ever high in LOAD, so this is a LOAD-state accept.
    assign accept = host_valid & host_ready_q;

    always_comb begin
        state_d      = state_q;
        host_ready_d = host_ready_q;
        we_im_d      = 1'b0;
        codein_d     = codein_q;
        im_addr_d    = im_addr_q;
        en_d         = en_q;
        done_d       = 1'b0;
        err_ovf_d    = err_ovf_q;
        word_count_d = word_count_q;
        checksum_d   = checksum_q;
        run_cnt_d    = run_cnt_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d      = S_LOAD;
                    host_ready_d = 1'b1;
                    im_addr_d    = '0;
                    word_count_d = '0;
                    checksum_d   = '0;
                end
            end
            S_LOAD: begin
                if (accept) begin
                    we_im_d      = 1'b1;
                    codein_d     = host_data;
                    im_addr_d    = word_count_q[AW-1:0];
                    word_count_d = word_count_q + {{AW{1'b0}}, 1'b1};
                    checksum_d   = checksum_q ^ host_data;
                end
                // stop wins over last/overflow; an accepted word is still written.
                if (stop) begin
                    state_d      = S_IDLE;
                    host_ready_d = 1'b0;
                end else if (accept && host_last) begin
                    state_d      = S_WRITE_LAST;
                    host_ready_d = 1'b0;
                end else if (accept && (word_count_q == LAST_SLOT)) begin
                    state_d      = S_FAULT;
                    host_ready_d = 1'b0;
                    err_ovf_d    = 1'b1;
                end
            end
            S_WRITE_LAST: begin
                state_d   = S_RUN;
                en_d      = 1'b1;
                run_cnt_d = '0;
            end
            S_RUN: begin
                run_cnt_d = run_cnt_q + 32'd1;
                if (stop || (RUN_BOUNDED && (run_cnt_q == RUN_LAST))) begin
                    state_d = S_IDLE;
                    en_d    = 1'b0;
                    done_d  = 1'b1;
                end
            end
            S_FAULT: begin
                if (clr_err) begin
                    state_d   = S_IDLE;
                    err_ovf_d = 1'b0;
                end
            end
            default: begin
                state_d      = S_IDLE;
                host_ready_d = 1'b0;
                en_d         = 1'b0;
            end
        endcase

        busy_d = (state_d == S_LOAD) || (state_d == S_WRITE_LAST) || (state_d == S_RUN);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_IDLE;
            host_ready_q <= 1'b0;
            we_im_q      <= 1'b0;
            codein_q     <= '0;
            im_addr_q    <= '0;
            en_q         <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            err_ovf_q    <= 1'b0;
            word_count_q <= '0;
            checksum_q   <= '0;
            run_cnt_q    <= '0;
        end else begin
            state_q      <= state_d;
            host_ready_q <= host_ready_d;
            we_im_q      <= we_im_d;
            codein_q     <= codein_d;
            im_addr_q    <= im_addr_d;
            en_q         <= en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            err_ovf_q    <= err_ovf_d;
            word_count_q <= word_count_d;
            checksum_q   <= checksum_d;
            run_cnt_q    <= run_cnt_d;
        end
    end

    assign host_ready = host_ready_q;
    assign we_IM      = we_im_q;
    assign codein     = codein_q;
    assign im_addr    = im_addr_q;
    assign en         = en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign err_ovf    = err_ovf_q;
    assign word_count = word_count_q;
    assign checksum   = checksum_q;
    assign dbg_state  = state_q;

endmodule

// File: tb/tb_cpu_prog_loader.sv
// Bench for cpu_prog_loader. Two instances share stimulus through a select:
// A has DEPTH=4 and a 10-cycle run window, B has DEPTH=16 and an open run.
module tb_cpu_prog_loader;

    localparam int AW      = 4;
    localparam int DEPTH_A = 4;
    localparam int RUN_A   = 10;
    localparam int DEPTH_B = 16;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // ---------------- stimulus and muxed observation ----------------
    logic        sel = 1'b0;
    logic        start = 1'b0, stop = 1'b0, clr_err = 1'b0;
    logic        host_valid = 1'b0, host_last = 1'b0;
    logic [18:0] host_data = '0;

    logic          a_host_ready, a_we, a_en, a_busy, a_done, a_err;
    logic [18:0]   a_codein, a_sum;
    logic [AW-1:0] a_addr;
    logic [AW:0]   a_cnt;
    logic [2:0]    a_state;
    logic          b_host_ready, b_we, b_en, b_busy, b_done, b_err;
    logic [18:0]   b_codein, b_sum;
    logic [AW-1:0] b_addr;
    logic [AW:0]   b_cnt;
    logic [2:0]    b_state;

    cpu_prog_loader #(.DEPTH(DEPTH_A), .AW(AW), .RUN_CYCLES(RUN_A)) dut_a (
        .clk(clk), .rst(rst), .start(start & ~sel), .stop(stop & ~sel),
        .clr_err(clr_err & ~sel), .host_valid(host_valid & ~sel),
        .host_data(host_data), .host_last(host_last),
        .host_ready(a_host_ready), .we_IM(a_we), .codein(a_codein), .im_addr(a_addr),
        .en(a_en), .busy(a_busy), .done(a_done), .err_ovf(a_err),
        .word_count(a_cnt), .checksum(a_sum), .dbg_state(a_state)
    );

    cpu_prog_loader #(.DEPTH(DEPTH_B), .AW(AW), .RUN_CYCLES(0)) dut_b (
        .clk(clk), .rst(rst), .start(start & sel), .stop(stop & sel),
        .clr_err(clr_err & sel), .host_valid(host_valid & sel),
        .host_data(host_data), .host_last(host_last),
        .host_ready(b_host_ready), .we_IM(b_we), .codein(b_codein), .im_addr(b_addr),
        .en(b_en), .busy(b_busy), .done(b_done), .err_ovf(b_err),
        .word_count(b_cnt), .checksum(b_sum), .dbg_state(b_state)
    );

    wire          host_ready = sel ? b_host_ready : a_host_ready;
    wire          we_im      = sel ? b_we : a_we;
    wire [18:0]   codein     = sel ? b_codein : a_codein;
    wire [AW-1:0] im_addr    = sel ? b_addr : a_addr;
    wire          en         = sel ? b_en : a_en;
    wire          busy       = sel ? b_busy : a_busy;
    wire          done       = sel ? b_done : a_done;
    wire          err_ovf    = sel ? b_err : a_err;
    wire [AW:0]   word_count = sel ? b_cnt : a_cnt;
    wire [18:0]   checksum   = sel ? b_sum : a_sum;
    wire [2:0]    dbg_state  = sel ? b_state : a_state;

    // ---------------- checking ----------------
    int n_checks = 0;
    int n_fail   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        n_checks++;
        if (act !== req) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    // Scoreboard entry: {write cycle[31:0], address[3:0], data[18:0]}
    logic [54:0] exp_q[$];

    // Reference model of the current load: words accepted so far and their XOR.
    int          m_cnt = 0;
    logic [18:0] m_sum = '0;
    int          last_wr_cyc = 0;

    int en_cnt = 0, done_cnt = 0, en_first = 0;
    bit en_seen = 0;

    // Monitor: every memory write must match the oldest expected write.
    always @(negedge clk) begin
        logic [54:0] e;
        if (!rst) begin
            if (en) begin
                en_cnt++;
                if (!en_seen) begin
                    en_seen  = 1;
                    en_first = cyc;
                end
            end
            if (done) done_cnt++;
            if (we_im) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_write", 64'd1, 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    check("wr_cycle", 64'(cyc), 64'(e[54:23]));
                    check("wr_addr", 64'(im_addr), 64'(e[22:19]));
                    check("wr_data", 64'(codein), 64'(e[18:0]));
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle();
        @(negedge clk);
        host_valid = 0; host_last = 0; stop = 0; start = 0; clr_err = 0;
    endtask

    task automatic beat(input logic v, input logic [18:0] d, input logic l,
                        input logic s, output logic acc);
        @(negedge clk);
        host_valid = v; host_data = d; host_last = l; stop = s;
        acc = v && host_ready;
        if (acc) begin
            exp_q.push_back({32'(cyc + 1), 4'(m_cnt), d});
            m_cnt++;
            m_sum ^= d;
            last_wr_cyc = cyc + 1;
        end
    endtask

    task automatic do_start();
        @(negedge clk);
        start = 1;
        m_cnt = 0; m_sum = '0;
        en_cnt = 0; done_cnt = 0; en_seen = 0;
        @(negedge clk);
        start = 0;
        check("start_busy", 64'(busy), 64'd1);
        check("start_ready", 64'(host_ready), 64'd1);
        check("start_clear", 64'({word_count, checksum}), 64'd0);
    endtask

    task automatic check_run_end(input int exp_en, input string tag);
        @(negedge clk);
        check({tag, "_en_cycles"}, 64'(en_cnt), 64'(exp_en));
        check({tag, "_en_onset"}, 64'(en_first), 64'(last_wr_cyc + 1));
        check({tag, "_done_count"}, 64'(done_cnt), 64'd1);
        check({tag, "_idle"}, 64'({dbg_state, busy, en, done}), 64'd0);
    endtask

    // Bounded wait for a self-terminating run window.
    task automatic wait_done(input int exp_en, input string tag);
        bit seen = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (done) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_done_seen"}, 64'(seen), 64'd1);
        check_run_end(exp_en, tag);
    endtask

    // End an open run with stop during its n-th enabled cycle.
    task automatic run_stop(input int n, input string tag);
        int k = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (en) k++;
            if (k == n) begin
                stop = 1;
                break;
            end
        end
        check({tag, "_reached_n"}, 64'(k), 64'(n));
        @(negedge clk);
        stop = 0;
        check({tag, "_done_pulse"}, 64'({en, done}), 64'b01);
        check_run_end(n, tag);
    endtask

    task automatic check_all_zero(input string tag);
        check(tag, {11'd0, host_ready, we_im, codein, im_addr, en, busy, done, err_ovf,
                    word_count, checksum}, 64'd0);
    endtask

    task automatic wait_en(input string tag);
        bit seen = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (en) begin
                seen = 1;
                break;
            end
        end
        check({tag, "_en_seen"}, 64'(seen), 64'd1);
    endtask

    // ---------------- test sequence ----------------
    initial begin
        logic acc;
        int   n, sent, guard, acc_total;
        logic [18:0] plan_words[4];
        plan_words[0] = 19'h00001; plan_words[1] = 19'h7FFFF;
        plan_words[2] = 19'h12345; plan_words[3] = 19'h00F0F;

        #1;
        check_all_zero("reset_outputs");
        check("reset_state", 64'(dbg_state), 64'd0);
        @(negedge clk);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        check_all_zero("post_reset_idle");

        // A: four back-to-back words, bounded 10-cycle run
        sel = 0;
        do_start();
        for (int i = 0; i < 4; i++) beat(1, plan_words[i], (i == 3), 0, acc);
        idle();
        check("plan_ready_low", 64'(host_ready), 64'd0);
        wait_done(RUN_A, "plan");
        check("plan_count", 64'(word_count), 64'd4);
        check("plan_sum", 64'(checksum), 64'(m_sum));
        check("plan_drained", 64'(exp_q.size()), 64'd0);

        // A: overflow with DEPTH=4
        do_start();
        acc_total = 0;
        for (int i = 0; i < 5; i++) begin
            beat(1, 19'($urandom), 0, 0, acc);
            if (acc) acc_total++;
        end
        idle();
        @(negedge clk);
        check("ovf_accepts", 64'(acc_total), 64'(DEPTH_A));
        check("ovf_fault", 64'({dbg_state, err_ovf, host_ready, busy}), 64'({3'd4, 3'b100}));
        check("ovf_count", 64'(word_count), 64'(DEPTH_A));
        @(negedge clk); start = 1;
        @(negedge clk); start = 0;
        @(negedge clk);
        check("ovf_start_ignored", 64'({dbg_state, err_ovf}), 64'({3'd4, 1'b1}));
        clr_err = 1;
        @(negedge clk); clr_err = 0;
        check("ovf_cleared", 64'({dbg_state, err_ovf}), 64'd0);
        check("ovf_drained", 64'(exp_q.size()), 64'd0);

        // B: valid gaps, then stop on the 7th enabled cycle
        @(negedge clk);
        sel = 1;
        do_start();
        beat(1, 19'h0ABCD, 0, 0, acc);
        beat(0, 19'h11111, 0, 0, acc);
        beat(0, 19'h22222, 0, 0, acc);
        beat(1, 19'h3C3C3, 0, 0, acc);
        beat(1, 19'h55AA5, 1, 0, acc);
        idle();
        run_stop(7, "gap");
        check("gap_count", 64'(word_count), 64'd3);
        check("gap_sum", 64'(checksum), 64'(m_sum));

        // B: stop in LOAD after two accepts
        do_start();
        beat(1, 19'($urandom), 0, 0, acc);
        beat(1, 19'($urandom), 0, 0, acc);
        beat(0, 19'd0, 0, 1, acc);
        idle();
        @(negedge clk);
        check("abort_idle", 64'({dbg_state, busy, en}), 64'd0);
        check("abort_count", 64'(word_count), 64'd2);
        check("abort_no_run", 64'({en_cnt[7:0], done_cnt[7:0]}), 64'd0);

        // B: stop together with an accept still writes the word
        do_start();
        beat(1, 19'($urandom), 0, 0, acc);
        beat(1, 19'($urandom), 1, 1, acc);
        idle();
        @(negedge clk);
        check("stop_acc_idle", 64'({dbg_state, busy}), 64'd0);
        check("stop_acc_count", 64'(word_count), 64'd2);
        check("stop_acc_sum", 64'(checksum), 64'(m_sum));

        // B: randomized images
        for (int r = 0; r < 5; r++) begin
            do_start();
            n = $urandom_range(1, 12);
            sent = 0;
            guard = 0;
            while (sent < n && guard < 200) begin
                if ($urandom_range(0, 3) != 0) beat(1, 19'($urandom), (sent == n - 1), 0, acc);
                else beat(0, 19'($urandom), 0, 0, acc);
                if (acc) sent++;
                guard++;
            end
            idle();
            check("rand_sent", 64'(sent), 64'(n));
            run_stop($urandom_range(1, 15), "rand");
            check("rand_count", 64'(word_count), 64'(n));
            check("rand_sum", 64'(checksum), 64'(m_sum));
        end

        // B: asynchronous reset mid-RUN
        do_start();
        beat(1, 19'h1F00F, 1, 0, acc);
        idle();
        wait_en("rst_run");
        @(negedge clk);
        #1 rst = 1;
        #1 check_all_zero("rst_mid_run");
        check("rst_mid_run_state", 64'(dbg_state), 64'd0);
        #1 rst = 0;
        exp_q.delete();

        // B: asynchronous reset mid-LOAD
        do_start();
        beat(1, 19'($urandom), 0, 0, acc);
        beat(1, 19'($urandom), 0, 0, acc);
        idle();
        #1 rst = 1;
        #1 check_all_zero("rst_mid_load");
        #1 rst = 0;
        exp_q.delete();

        // Fresh load after reset starts at address 0
        do_start();
        beat(1, 19'h6A5A5, 1, 0, acc);
        idle();
        run_stop(3, "after_rst");
        check("after_rst_count", 64'(word_count), 64'd1);
        check("after_rst_sum", 64'(checksum), 64'h6A5A5);

        repeat (3) @(negedge clk);
        check("final_drained", 64'(exp_q.size()), 64'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
